// File: rtl/seq_det_pkg.sv
// Shared definitions for the sequence detector family.
// State encoding used by the serializer and later FSM stages.
package seq_det_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end for the sequence detectors.
// Words stream back to back with no idle bubble between them.
module seq_bit_serializer
  import seq_det_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic             last;
  logic             accept;

  assign last   = (state == S_SHIFT) && (cnt == '0);
  assign accept = in_valid && in_ready;

  // Move the register one place toward the output end, zero fill.
  always_comb begin
    shreg_nxt = '0;
    if (MSB_FIRST)
      shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
    else
      shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
  end

  // State, bit counter and shift register; reload on the last bit keeps words contiguous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            state <= S_SHIFT;
            cnt   <= LAST;
            shreg <= in_data;
          end
        end
        S_SHIFT: begin
          if (cnt == '0) begin
            if (accept) begin
              cnt   <= LAST;
              shreg <= in_data;
            end else begin
              state <= S_IDLE;
              shreg <= shreg_nxt;
            end
          end else begin
            cnt   <= cnt - 1'b1;
            shreg <= shreg_nxt;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from registers only.
  always_comb begin
    busy      = (state == S_SHIFT);
    bit_valid = busy;
    word_done = last;
    in_ready  = (state == S_IDLE) || last;
    bit_out   = 1'b0;
    if (busy)
      bit_out = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  end

endmodule
